// File: rtl/inst_fetch_unit_pkg.sv
// Shared widths and constants for the instruction fetch unit.
package inst_fetch_unit_pkg;

  localparam int          INST_BUS_W      = 32;
  localparam int          INST_ADDR_BUS_W = 32;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
  localparam int          PC_INC          = 4;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible on rdata
// whenever the FIFO is non-empty.
module fetch_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rdata,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;
  assign rdata = r_mem[r_rd_ptr];

  // A push into a full FIFO is allowed when the head leaves in the same cycle.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Sequential instruction prefetcher between the core fetch stage and a pipelined
// instruction memory, with redirect flush and stale-response discard.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_BUS_W,
  parameter int                DATA_W   = INST_BUS_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int                CW      = cnt_w(DEPTH);
  localparam logic [CW:0]       DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] INC     = ADDR_W'(PC_INC);

  logic [ADDR_W-1:0]        r_fetch_pc;
  logic [ADDR_W-1:0]        r_resp_pc;
  logic [CW-1:0]            r_outst;
  logic [CW-1:0]            r_discard;

  logic [CW-1:0]            w_count;
  logic                     w_empty;
  logic                     w_full;
  logic [ADDR_W+DATA_W-1:0] w_head;
  logic                     w_rv_acc;
  logic                     w_push;
  logic                     w_pop;
  logic [ADDR_W-1:0]        w_redir_pc;
  logic [1:0]               w_unused_pc_bits;

  assign w_unused_pc_bits = redirect_pc_i[1:0];
  assign w_redir_pc       = {redirect_pc_i[ADDR_W-1:2], 2'b00};

  // Credit covers buffered entries plus every in-flight request, including ones
  // that will be discarded, so a response always finds room in the FIFO.
  assign mem_req_o  = !rst && !redirect_valid_i &&
                      (({1'b0, w_count} + {1'b0, r_outst}) < DEPTH_C);
  assign mem_addr_o = r_fetch_pc;

  assign w_rv_acc = mem_rvalid_i && (r_outst != '0);
  assign w_push   = w_rv_acc && (r_discard == '0) && !redirect_valid_i;
  assign w_pop    = inst_valid_o && inst_ready_i;

  assign inst_valid_o = !w_empty && !redirect_valid_i;
  assign inst_o       = w_empty ? '0 : w_head[DATA_W-1:0];
  assign inst_pc_o    = w_empty ? '0 : w_head[ADDR_W+DATA_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_outst    <= '0;
      r_discard  <= '0;
    end else begin
      case ({mem_req_o, w_rv_acc})
        2'b10:   r_outst <= r_outst + CW'(1);
        2'b01:   r_outst <= r_outst - CW'(1);
        default: r_outst <= r_outst;
      endcase

      if (redirect_valid_i) begin
        r_fetch_pc <= w_redir_pc;
        r_resp_pc  <= w_redir_pc;
        r_discard  <= r_outst - CW'(w_rv_acc);
      end else begin
        if (mem_req_o) r_fetch_pc <= r_fetch_pc + INC;
        if (w_push)    r_resp_pc  <= r_resp_pc + INC;
        if (w_rv_acc && (r_discard != '0)) r_discard <= r_discard - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .wdata ({r_resp_pc, mem_rdata_i}),
    .pop   (w_pop),
    .flush (redirect_valid_i),
    .rdata (w_head),
    .count (w_count),
    .empty (w_empty),
    .full  (w_full)
  );

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(w_push && w_full && !w_pop));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: a latency-configurable memory model
// feeds a scoreboard of expected instructions in program order.
module tb_inst_fetch_unit;

  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              redirect_valid_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              inst_valid_o;
  logic              inst_ready_i;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  inst_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_rvalid_i     (mem_rvalid_i),
    .mem_rdata_i      (mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          orphan;
    bit          stale;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } inst_t;

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] first_pc;
    logic [31:0] second_pc;
    int          lat;
  } vec_t;

  pend_t       pend[$];
  inst_t       sb[$];
  int          checks;
  int          failures;
  int          cyc;
  int          lat;
  int          tb_outst;
  int          tb_buf;
  int          req_cnt;
  int          pop_cnt;
  int          first_valid_cyc;
  bit          popped;
  logic [31:0] pop_pc;
  logic [31:0] exp_fetch_pc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive memory response, check outputs against the model,
  // advance the model, then move to the next falling edge.
  task automatic tick();
    pend_t rsp;
    bit    have_rsp;
    inst_t e;
    have_rsp     = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rsp          = pend.pop_front();
      have_rsp     = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_data(rsp.addr);
    end
    #1;
    popped = 1'b0;
    chk("mem_req", 64'(mem_req_o),
        64'(!rst && !redirect_valid_i && (tb_buf + tb_outst < DEPTH)));
    if (mem_req_o) chk("mem_addr", mem_addr_o, exp_fetch_pc);
    if (!rst) begin
      chk("inst_valid", 64'(inst_valid_o), 64'(tb_buf > 0 && !redirect_valid_i));
      if (inst_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (inst_valid_o && inst_ready_i) begin
        popped = 1'b1;
        pop_pc = inst_pc_o;
        pop_cnt++;
        chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("inst_pc", inst_pc_o, e.pc);
          chk("inst_data", inst_o, e.data);
        end
        if (tb_buf > 0) tb_buf--;
      end
    end
    if (have_rsp && !rsp.orphan) begin
      tb_outst--;
      if (!rsp.stale && !redirect_valid_i && !rst) tb_buf++;
    end
    if (mem_req_o) begin
      pend.push_back('{addr: mem_addr_o, due: cyc + lat, orphan: 1'b0, stale: 1'b0});
      req_cnt++;
      tb_outst++;
      sb.push_back('{pc: exp_fetch_pc, data: mem_data(exp_fetch_pc)});
      exp_fetch_pc = exp_fetch_pc + 32'd4;
    end
    if (redirect_valid_i && !rst) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      tb_buf = 0;
      sb.delete();
      exp_fetch_pc = {redirect_pc_i[31:2], 2'b00};
    end
    if (rst) begin
      foreach (pend[i]) pend[i].orphan = 1'b1;
      tb_outst = 0;
      tb_buf   = 0;
      sb.delete();
      exp_fetch_pc = RESET_PC;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = pc;
    tick();
    redirect_valid_i = 1'b0;
  endtask

  // Waits for the next two pops and compares their PCs.
  task automatic expect_two_pops(input string name, input logic [31:0] pc0, input logic [31:0] pc1);
    int got;
    got = 0;
    for (int k = 0; k < 30 && got < 2; k++) begin
      tick();
      if (popped) begin
        if (got == 0) chk({name, "_first_pc"}, pop_pc, pc0);
        else          chk({name, "_second_pc"}, pop_pc, pc1);
        got++;
      end
    end
    chk({name, "_pops_seen"}, 64'(got), 64'd2);
  endtask

  vec_t vecs[5];
  int   rel_cyc;

  initial begin
    vecs[0] = '{tgt: 32'h0000_0100, first_pc: 32'h0000_0100, second_pc: 32'h0000_0104, lat: 3};
    vecs[1] = '{tgt: 32'h0000_0203, first_pc: 32'h0000_0200, second_pc: 32'h0000_0204, lat: 1};
    vecs[2] = '{tgt: 32'hFFFF_FFFC, first_pc: 32'hFFFF_FFFC, second_pc: 32'h0000_0000, lat: 2};
    vecs[3] = '{tgt: 32'h0000_1001, first_pc: 32'h0000_1000, second_pc: 32'h0000_1004, lat: 3};
    vecs[4] = '{tgt: 32'h0000_0A0A, first_pc: 32'h0000_0A08, second_pc: 32'h0000_0A0C, lat: 1};

    checks = 0; failures = 0; cyc = 0; lat = 1;
    tb_outst = 0; tb_buf = 0; req_cnt = 0; pop_cnt = 0;
    first_valid_cyc = -1; exp_fetch_pc = RESET_PC;
    rst = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0;
    inst_ready_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    @(negedge clk);

    // Reset values
    tick(); tick();
    #1;
    chk("rst_inst_valid", 64'(inst_valid_o), 64'd0);
    chk("rst_inst_o", inst_o, 64'd0);
    chk("rst_inst_pc", inst_pc_o, 64'd0);
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_mem_addr", mem_addr_o, RESET_PC);

    // Streaming with 1-cycle memory
    rst = 1'b0;
    first_valid_cyc = -1;
    rel_cyc = cyc;
    pop_cnt = 0;
    repeat (12) tick();
    chk("first_valid_latency", 64'(first_valid_cyc - rel_cyc), 64'd2);
    chk("stream_pops", 64'(pop_cnt), 64'd10);

    // Back-pressure fills exactly DEPTH credits
    reset_dut(2);
    inst_ready_i = 1'b0;
    req_cnt = 0;
    repeat (10) tick();
    chk("stall_req_cnt", 64'(req_cnt), 64'(DEPTH));
    #1;
    chk("stall_mem_req", 64'(mem_req_o), 64'd0);
    chk("stall_valid", 64'(inst_valid_o), 64'd1);
    inst_ready_i = 1'b1;
    pop_cnt = 0;
    repeat (4) tick();
    chk("resume_pops", 64'(pop_cnt), 64'd4);

    // Redirect table: target, aligned first PC, next PC, memory latency
    for (int v = 0; v < 5; v++) begin
      lat = vecs[v].lat;
      repeat (8) tick();
      redirect(vecs[v].tgt);
      expect_two_pops($sformatf("redir%0d", v), vecs[v].first_pc, vecs[v].second_pc);
    end

    // Redirect coinciding with the only outstanding response
    lat = 1;
    repeat (6) tick();
    chk("rv_redir_setup", 64'(pend.size() > 0 && pend[0].due <= cyc), 64'd1);
    redirect(32'h0000_0100);
    #1;
    chk("rv_redir_req", 64'(mem_req_o), 64'd1);
    chk("rv_redir_addr", mem_addr_o, 64'h100);
    expect_two_pops("rv_redir", 32'h100, 32'h104);

    // Back-to-back redirects: last one wins
    lat = 2;
    repeat (6) tick();
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h0000_0300;
    tick();
    redirect(32'h0000_0400);
    expect_two_pops("b2b_redir", 32'h400, 32'h404);

    // Reset with two responses in flight
    lat = 2;
    repeat (8) tick();
    reset_dut(1);
    #1;
    chk("midrst_inst_valid", 64'(inst_valid_o), 64'd0);
    chk("midrst_inst_o", inst_o, 64'd0);
    chk("midrst_mem_addr", mem_addr_o, RESET_PC);
    expect_two_pops("midrst", RESET_PC, RESET_PC + 32'd4);

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Parametrised successor to the direct core-to-inst_rom connection.
- Sits between the core's fetch stage and a pipelined instruction memory. Issues sequential fetch requests, tolerates in-order memory latency, and buffers responses in a prefetch FIFO.
- Presents instructions with valid/ready handshake.
- Handles PC redirects (branch/jump): flushes the buffer and discards stale in-flight responses.

Parameters:
- ADDR_W, 32, instruction address width.
- DATA_W, 32, instruction width.
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2; also caps outstanding requests.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- redirect_valid_i  in  1  core requests fetch restart.
- redirect_pc_i  in  ADDR_W  new fetch address; bits [1:0] ignored (forced 0).
- inst_valid_o  out  1  inst_o/inst_pc_o valid.
- inst_ready_i  in  1  core accepts instruction.
- inst_o  out  DATA_W  instruction.
- inst_pc_o  out  ADDR_W  address of inst_o.
- mem_req_o  out  1  fetch request; memory accepts every request, no stall.
- mem_addr_o  out  ADDR_W  request address.
- mem_rvalid_i  in  1  response valid; responses in request order, >= 1 cycle after request.
- mem_rdata_i  in  DATA_W  response data.

Behaviour:
- Reset state when rst=1 at a clock edge:
  - fetch_pc = RESET_PC, resp_pc = RESET_PC.
  - FIFO empty; outstanding = 0; discard = 0.
  - Outputs: inst_valid_o=0, inst_o=0, inst_pc_o=0, mem_req_o=0, mem_addr_o=RESET_PC.
  - Reset mid-operation drops everything; responses arriving after reset are ignored, because outstanding=0.
- Request issue (combinational):
  - mem_req_o = !rst && !redirect_valid_i && (fifo_count + outstanding < DEPTH).
  - mem_addr_o = fetch_pc.
  - On each request, fetch_pc <= fetch_pc + 4, wrapping modulo 2^ADDR_W.
- Outstanding counter:
  - +1 on request, -1 on mem_rvalid_i; both in the same cycle leaves it unchanged.
  - mem_rvalid_i while outstanding==0 is ignored.
- Response handling:
  - If discard>0: drop the response, discard -1.
  - Else: push {resp_pc, mem_rdata_i} into the FIFO and set resp_pc += 4.
  - The credit rule guarantees no push when full; push and pop in the same cycle when full is legal.
- Output:
  - First-word fall-through, registered storage; inst_valid_o = !fifo_empty && !redirect_valid_i.
  - inst_o/inst_pc_o come from the FIFO head and hold stable while valid && !ready.
  - Pop on inst_valid_o && inst_ready_i.
- Latency: a response is visible on inst_valid_o the cycle after mem_rvalid_i. With 1-cycle memory after reset release:
  - request at cycle 0;
  - rvalid at cycle 1;
  - inst_valid_o at cycle 2.
- Redirect (redirect_valid_i=1), applied at the clock edge:
  - FIFO flushed, no pop.
  - discard <= outstanding - mem_rvalid_i. This covers all in-flight requests and already includes any prior discards. A response arriving in the redirect cycle is dropped.
  - fetch_pc and resp_pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00}.
  - No request in the redirect cycle. Requests resume next cycle if credit allows; credit counts discarded in-flight requests.
- Back-to-back redirects: each restarts; the last one wins.
- Redirect and rst together: rst wins.
- Counters are $clog2(DEPTH)+1 bits wide.

Decomposition:
- Shared defines file:
  - instruction/address bus width macros (InstBus, InstAddrBus);
  - reset PC constant;
  - PC increment constant 4.
- One natural sub-module: fetch_fifo — synchronous FWFT FIFO, parameters WIDTH and DEPTH, with push/pop/flush/count/empty/full.
- inst_fetch_unit instantiates fetch_fifo with WIDTH = ADDR_W + DATA_W.

Test Plan:
- Reset, 1-cycle memory, ready=1 → requests at 0x0, 0x4, 0x8… one per cycle; inst_pc_o sequence 0x0, 0x4, 0x8 with matching data; first inst_valid_o two cycles after rst deasserts.
- ready=0 with DEPTH=4 → exactly 4 requests issued, then mem_req_o=0. Raising ready → one pop per cycle, requests resume one cycle per freed slot.
- 3-cycle memory latency, 3 requests in flight, redirect to 0x100 → 3 stale responses dropped; the next valid instruction has inst_pc_o=0x100 with data from addr 0x100.
- Redirect in the same cycle as mem_rvalid_i with outstanding=1 → discard=0, response dropped, no request that cycle; next request addr=0x100.
- Redirect to 0x203 → fetch resumes at 0x200. Redirect to 0xFFFF_FFFC → fetch wraps to 0x0000_0000.
- rst asserted with 2 responses in flight → outputs return to reset values; late rvalids produce no inst_valid_o; fetch restarts at RESET_PC.
